// File: rtl/gpu_load_store_unit_if.sv
// Core request/response and data-RAM signal bundle of the GPU load/store unit.
// slave is the unit's view; master is the core-plus-RAM side.
interface gpu_load_store_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 16
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_is_store;
    logic [2:0]               req_funct3;
    logic [31:0]              req_address;
    logic [31:0]              req_store_data;
    logic                     resp_valid;
    logic                     resp_fault;
    logic [31:0]              resp_load_data;
    logic [ADDRESS_WIDTH-3:0] mem_address;
    logic                     mem_write;
    logic [3:0]               mem_byte_enable;
    logic [31:0]              mem_write_data;
    logic [31:0]              mem_read_data;

    modport master (
        output req_valid, req_is_store, req_funct3, req_address, req_store_data, mem_read_data,
        input  req_ready, resp_valid, resp_fault, resp_load_data,
               mem_address, mem_write, mem_byte_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_address, req_store_data, mem_read_data,
        output req_ready, resp_valid, resp_fault, resp_load_data,
               mem_address, mem_write, mem_byte_enable, mem_write_data
    );
endinterface

// File: rtl/gpu_load_store_unit.sv
// RV32 load/store unit: lane steering, sign extension, fault detection and
// optional read-modify-write for narrow stores on RAMs without byte enables.
module gpu_load_store_unit #(
    parameter int unsigned ADDRESS_WIDTH    = 16,
    parameter int unsigned READ_LATENCY     = 1,
    parameter bit          HAS_BYTE_ENABLES = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    gpu_load_store_unit_if.slave bus
);
    localparam int unsigned WORD_AW = ADDRESS_WIDTH - 2;
    localparam int unsigned CNT_W   = 3;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] READ_WAIT = 3'd1;
    localparam logic [2:0] RMW_WRITE = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("gpu_load_store_unit: READ_LATENCY must be 1..4");
        end
    endgenerate

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_store_q, op_store_d;
    logic [2:0]         op_f3_q, op_f3_d;
    logic [1:0]         op_lo_q, op_lo_d;
    logic [31:0]        op_data_q, op_data_d;
    logic [WORD_AW-1:0] addr_q, addr_d;
    logic               write_q, write_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rvalid_q, rvalid_d;
    logic               rfault_q, rfault_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bad_f3_c, misalign_c, range_c, req_fault_c;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'd0:    return {4{data[7:0]}};
            3'd1:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'd0:    return 4'b0001 << lo;
            3'd1:    return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rmw_merge(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lo, input logic [31:0] data);
        logic [31:0] r;
        r = word;
        case (f3)
            3'd0:    r[{lo, 3'b000} +: 8]     = data[7:0];
            3'd1:    r[{lo[1], 4'b0000} +: 16] = data[15:0];
            default: r = data;
        endcase
        return r;
    endfunction

    // Fault decode on the raw request, evaluated in the acceptance cycle
    always_comb begin
        bad_f3_c    = bus.req_is_store ? (bus.req_funct3 >= 3'd3)
                                       : (bus.req_funct3 == 3'd3 || bus.req_funct3 >= 3'd6);
        misalign_c  = (bus.req_funct3[1:0] == 2'b01 && bus.req_address[0]) ||
                      (bus.req_funct3[1:0] == 2'b10 && bus.req_address[1:0] != 2'b00);
        range_c     = |bus.req_address[31:ADDRESS_WIDTH];
        req_fault_c = bad_f3_c || misalign_c || range_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_store_d = op_store_q;
        op_f3_d    = op_f3_q;
        op_lo_d    = op_lo_q;
        op_data_d  = op_data_q;
        addr_d     = addr_q;
        write_d    = 1'b0;
        be_d       = HAS_BYTE_ENABLES ? be_q : 4'b1111;
        wdata_d    = wdata_q;
        rvalid_d   = 1'b0;
        rfault_d   = 1'b0;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_store_d = bus.req_is_store;
                    op_f3_d    = bus.req_funct3;
                    op_lo_d    = bus.req_address[1:0];
                    op_data_d  = bus.req_store_data;
                    // Faults answer straight from IDLE so the core never sees a bubble
                    if (req_fault_c) begin
                        rvalid_d = 1'b1;
                        rfault_d = 1'b1;
                        rdata_d  = 32'd0;
                    end else if (bus.req_is_store && (bus.req_funct3 == 3'd2 || HAS_BYTE_ENABLES)) begin
                        state_d = WRITE;
                        addr_d  = bus.req_address[ADDRESS_WIDTH-1:2];
                        write_d = 1'b1;
                        be_d    = HAS_BYTE_ENABLES ? store_be(bus.req_funct3, bus.req_address[1:0])
                                                   : 4'b1111;
                        wdata_d = store_lanes(bus.req_funct3, bus.req_store_data);
                    end else begin
                        state_d = READ_WAIT;
                        addr_d  = bus.req_address[ADDRESS_WIDTH-1:2];
                        cnt_d   = '0;
                    end
                end
            end
            READ_WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY)) begin
                    if (op_store_q) begin
                        state_d = RMW_WRITE;
                        write_d = 1'b1;
                        be_d    = 4'b1111;
                        wdata_d = rmw_merge(bus.mem_read_data, op_f3_q, op_lo_q, op_data_q);
                    end else begin
                        state_d  = IDLE;
                        rvalid_d = 1'b1;
                        rdata_d  = load_extend(bus.mem_read_data, op_f3_q, op_lo_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE, RMW_WRITE: begin
                state_d  = IDLE;
                rvalid_d = 1'b1;
                rdata_d  = 32'd0;
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_store_q <= 1'b0;
            op_f3_q    <= 3'd0;
            op_lo_q    <= 2'd0;
            op_data_q  <= 32'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            rfault_q   <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_store_q <= op_store_d;
            op_f3_q    <= op_f3_d;
            op_lo_q    <= op_lo_d;
            op_data_q  <= op_data_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rvalid_q   <= rvalid_d;
            rfault_q   <= rfault_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.req_ready       = (state_q == IDLE) && !reset;
    assign bus.resp_valid      = rvalid_q;
    assign bus.resp_fault      = rfault_q;
    assign bus.resp_load_data  = rdata_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_write       = write_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_write_data  = wdata_q;
endmodule

// File: tb/tb_gpu_load_store_unit.sv
// Directed bench: unit A (latency 1, byte enables) and unit B (latency 3,
// read-modify-write) each driving its own behavioural synchronous RAM.
module tb_gpu_load_store_unit;
    localparam int unsigned AW    = 16;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gpu_load_store_unit_if #(.ADDRESS_WIDTH(AW)) if_a ();
    gpu_load_store_unit_if #(.ADDRESS_WIDTH(AW)) if_b ();

    gpu_load_store_unit #(.ADDRESS_WIDTH(AW), .READ_LATENCY(LAT_A), .HAS_BYTE_ENABLES(1'b1))
        dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    gpu_load_store_unit #(.ADDRESS_WIDTH(AW), .READ_LATENCY(LAT_B), .HAS_BYTE_ENABLES(1'b0))
        dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));

    logic        sel;
    logic        req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address, req_store_data;

    assign if_a.req_valid      = req_valid & ~sel;
    assign if_b.req_valid      = req_valid & sel;
    assign if_a.req_is_store   = req_is_store;
    assign if_b.req_is_store   = req_is_store;
    assign if_a.req_funct3     = req_funct3;
    assign if_b.req_funct3     = req_funct3;
    assign if_a.req_address    = req_address;
    assign if_b.req_address    = req_address;
    assign if_a.req_store_data = req_store_data;
    assign if_b.req_store_data = req_store_data;

    logic          obs_ready, obs_resp_valid, obs_fault, obs_write;
    logic [31:0]   obs_rdata, obs_wdata;
    logic [3:0]    obs_be;
    logic [AW-3:0] obs_addr;
    assign obs_ready      = sel ? if_b.req_ready       : if_a.req_ready;
    assign obs_resp_valid = sel ? if_b.resp_valid      : if_a.resp_valid;
    assign obs_fault      = sel ? if_b.resp_fault      : if_a.resp_fault;
    assign obs_write      = sel ? if_b.mem_write       : if_a.mem_write;
    assign obs_rdata      = sel ? if_b.resp_load_data  : if_a.resp_load_data;
    assign obs_wdata      = sel ? if_b.mem_write_data  : if_a.mem_write_data;
    assign obs_be         = sel ? if_b.mem_byte_enable : if_a.mem_byte_enable;
    assign obs_addr       = sel ? if_b.mem_address     : if_a.mem_address;

    // Behavioural RAMs: read data appears LAT cycles after the address
    logic [31:0] ram_a [0:255];
    logic [31:0] ram_b [0:255];
    logic [31:0] pipe_a [0:3];
    logic [31:0] pipe_b [0:3];
    logic        pre_en, pre_sel;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (pre_en && !pre_sel) ram_a[pre_addr] <= pre_data;
        else if (if_a.mem_write)
            ram_a[if_a.mem_address[7:0]] <= be_merge(ram_a[if_a.mem_address[7:0]],
                                                     if_a.mem_write_data, if_a.mem_byte_enable);
        pipe_a[0] <= ram_a[if_a.mem_address[7:0]];
        for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end

    always @(posedge clock) begin
        if (pre_en && pre_sel) ram_b[pre_addr] <= pre_data;
        else if (if_b.mem_write)
            ram_b[if_b.mem_address[7:0]] <= be_merge(ram_b[if_b.mem_address[7:0]],
                                                     if_b.mem_write_data, if_b.mem_byte_enable);
        pipe_b[0] <= ram_b[if_b.mem_address[7:0]];
        for (int j = 1; j < 4; j++) pipe_b[j] <= pipe_b[j-1];
    end

    assign if_a.mem_read_data = pipe_a[LAT_A-1];
    assign if_b.mem_read_data = pipe_b[LAT_B-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic which, input logic [7:0] addr, input logic [31:0] data);
        pre_sel  = which;
        pre_addr = addr;
        pre_data = data;
        pre_en   = 1'b1;
        @(negedge clock);
        pre_en   = 1'b0;
    endtask

    // Present one request at a negedge; return at the negedge of cycle T+1
    task automatic issue(input logic which, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        sel            = which;
        req_is_store   = st;
        req_funct3     = f3;
        req_address    = addr;
        req_store_data = data;
        req_valid      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid      = 1'b0;
    endtask

    // kind 0 waits for resp_valid, kind 1 for mem_write; at = cycle offset from T, -1 on timeout
    task automatic wait_for(input int kind, input int from, input int limit, output int at);
        at = from;
        while (((kind == 0) ? !obs_resp_valid : !obs_write) && at < limit) begin
            @(negedge clock);
            at++;
        end
        if ((kind == 0) ? !obs_resp_valid : !obs_write) at = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic        f_st   [0:6];
    logic [2:0]  f_f3   [0:6];
    logic [31:0] f_addr [0:6];
    int at;

    initial begin
        sel = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_address = 32'd0; req_store_data = 32'd0;
        pre_en = 1'b0; pre_sel = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
        f_st[0] = 0; f_f3[0] = 3'd2; f_addr[0] = 32'h0000_0002;
        f_st[1] = 1; f_f3[1] = 3'd1; f_addr[1] = 32'h0000_0001;
        f_st[2] = 0; f_f3[2] = 3'd2; f_addr[2] = 32'h0001_0000;
        f_st[3] = 0; f_f3[3] = 3'd3; f_addr[3] = 32'h0000_0000;
        f_st[4] = 1; f_f3[4] = 3'd3; f_addr[4] = 32'h0000_0000;
        f_st[5] = 0; f_f3[5] = 3'd5; f_addr[5] = 32'h0000_0003;
        f_st[6] = 1; f_f3[6] = 3'd0; f_addr[6] = 32'h8000_0000;

        #2;
        check("rst_ready", 32'(obs_ready), 32'd0);
        check("rst_resp_valid", 32'(obs_resp_valid), 32'd0);
        check("rst_fault", 32'(obs_fault), 32'd0);
        check("rst_write", 32'(obs_write), 32'd0);
        check("rst_be", 32'(obs_be), 32'd0);
        check("rst_addr", 32'(obs_addr), 32'd0);
        check("rst_wdata", obs_wdata, 32'd0);
        check("rst_rdata", obs_rdata, 32'd0);
        check("rst_b_be", 32'(if_b.mem_byte_enable), 32'd0);

        @(negedge clock);
        preload(1'b0, 8'd4, 32'hDEAD_BEEF);
        preload(1'b0, 8'd1, 32'h0000_0000);
        preload(1'b1, 8'd1, 32'hAABB_CCDD);
        reset = 1'b0;
        #1 check("ready_after_reset", 32'(obs_ready), 32'd1);
        @(negedge clock);

        // LW, latency 1
        issue(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'd0);
        check("lw_addr", 32'(obs_addr), 32'd4);
        wait_for(0, 1, 12, at);
        check("lw_resp_cycle", 32'(at), 32'd3);
        check("lw_data", obs_rdata, 32'hDEAD_BEEF);
        check("lw_fault", 32'(obs_fault), 32'd0);
        check("lw_ready_with_resp", 32'(obs_ready), 32'd1);

        // Lane steering and extension
        preload(1'b0, 8'd4, 32'h80FF_0000);
        issue(1'b0, 1'b0, 3'd0, 32'h0000_0013, 32'd0);
        wait_for(0, 1, 12, at);
        check("lb_13", obs_rdata, 32'hFFFF_FF80);
        issue(1'b0, 1'b0, 3'd4, 32'h0000_0013, 32'd0);
        wait_for(0, 1, 12, at);
        check("lbu_13", obs_rdata, 32'h0000_0080);
        issue(1'b0, 1'b0, 3'd1, 32'h0000_0012, 32'd0);
        wait_for(0, 1, 12, at);
        check("lh_12", obs_rdata, 32'hFFFF_80FF);
        issue(1'b0, 1'b0, 3'd5, 32'h0000_0012, 32'd0);
        wait_for(0, 1, 12, at);
        check("lhu_12", obs_rdata, 32'h0000_80FF);
        issue(1'b0, 1'b0, 3'd0, 32'h0000_0012, 32'd0);
        wait_for(0, 1, 12, at);
        check("lb_12", obs_rdata, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 3'd4, 32'h0000_0010, 32'd0);
        wait_for(0, 1, 12, at);
        check("lbu_10", obs_rdata, 32'h0000_0000);

        // Narrow stores with byte enables
        issue(1'b0, 1'b1, 3'd0, 32'h0000_0005, 32'h1234_5678);
        check("sb_write", 32'(obs_write), 32'd1);
        check("sb_addr", 32'(obs_addr), 32'd1);
        check("sb_be", 32'(obs_be), 32'b0010);
        check("sb_wdata", obs_wdata, 32'h7878_7878);
        @(negedge clock);
        check("sb_resp", 32'(obs_resp_valid), 32'd1);
        check("sb_write_done", 32'(obs_write), 32'd0);
        check("sb_rdata_zero", obs_rdata, 32'd0);
        issue(1'b0, 1'b1, 3'd1, 32'h0000_0006, 32'h0000_5678);
        check("sh_be", 32'(obs_be), 32'b1100);
        check("sh_wdata", obs_wdata, 32'h5678_5678);
        @(negedge clock);
        check("sh_resp", 32'(obs_resp_valid), 32'd1);
        issue(1'b0, 1'b0, 3'd2, 32'h0000_0004, 32'd0);
        wait_for(0, 1, 12, at);
        check("lw_after_narrow", obs_rdata, 32'h5678_7800);

        // Read-modify-write, latency 3
        issue(1'b1, 1'b1, 3'd1, 32'h0000_0006, 32'h0000_1234);
        check("rmw_sh_no_early_write", 32'(obs_write), 32'd0);
        check("rmw_sh_addr_t1", 32'(obs_addr), 32'd1);
        wait_for(1, 1, 12, at);
        check("rmw_sh_write_cycle", 32'(at), 32'd5);
        check("rmw_sh_wdata", obs_wdata, 32'h1234_CCDD);
        check("rmw_sh_be", 32'(obs_be), 32'hF);
        check("rmw_sh_addr_wr", 32'(obs_addr), 32'd1);
        @(negedge clock);
        wait_for(0, 6, 14, at);
        check("rmw_sh_resp_cycle", 32'(at), 32'd6);
        check("rmw_sh_fault", 32'(obs_fault), 32'd0);
        issue(1'b1, 1'b1, 3'd0, 32'h0000_0004, 32'h0000_00EE);
        wait_for(1, 1, 12, at);
        check("rmw_sb_write_cycle", 32'(at), 32'd5);
        check("rmw_sb_wdata", obs_wdata, 32'h1234_CCEE);
        @(negedge clock);
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0004, 32'd0);
        wait_for(0, 1, 14, at);
        check("b_lw_resp_cycle", 32'(at), 32'd5);
        check("b_lw_data", obs_rdata, 32'h1234_CCEE);
        issue(1'b1, 1'b1, 3'd2, 32'h0000_0008, 32'hCAFE_F00D);
        check("b_sw_write", 32'(obs_write), 32'd1);
        check("b_sw_be", 32'(obs_be), 32'hF);
        check("b_sw_wdata", obs_wdata, 32'hCAFE_F00D);
        @(negedge clock);
        check("b_sw_resp", 32'(obs_resp_valid), 32'd1);

        // Faults: response in T+1, no RAM write, zero data
        for (int k = 0; k < 7; k++) begin
            issue(1'b0, f_st[k], f_f3[k], f_addr[k], 32'hFFFF_FFFF);
            check($sformatf("fault%0d_resp", k), 32'(obs_resp_valid), 32'd1);
            check($sformatf("fault%0d_flag", k), 32'(obs_fault), 32'd1);
            check($sformatf("fault%0d_write", k), 32'(obs_write), 32'd0);
            check($sformatf("fault%0d_rdata", k), obs_rdata, 32'd0);
        end

        // Back-to-back SW then LW with req_valid held
        sel = 1'b0; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_address = 32'h0000_0020; req_store_data = 32'h5A5A_A5A5; req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_is_store = 1'b0; req_store_data = 32'd0;
        check("b2b_sw_write", 32'(obs_write), 32'd1);
        check("b2b_busy", 32'(obs_ready), 32'd0);
        @(negedge clock);
        check("b2b_sw_resp", 32'(obs_resp_valid), 32'd1);
        check("b2b_ready_with_resp", 32'(obs_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_for(0, 1, 12, at);
        check("b2b_lw_resp_cycle", 32'(at), 32'd3);
        check("b2b_lw_data", obs_rdata, 32'h5A5A_A5A5);

        // Reset while waiting on a read
        issue(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'd0);
        reset = 1'b1;
        #1 check("rst_rw_ready", 32'(obs_ready), 32'd0);
        check("rst_rw_resp", 32'(obs_resp_valid), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 check("rst_rw_ready_after", 32'(obs_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("rst_rw_no_resp%0d", k), 32'(obs_resp_valid), 32'd0);
        end

        // Reset during the RMW write drops mem_write at once
        issue(1'b1, 1'b1, 3'd1, 32'h0000_0006, 32'h0000_9999);
        wait_for(1, 1, 12, at);
        check("rst_rmw_write_seen", 32'(at), 32'd5);
        reset = 1'b1;
        #1 check("rst_rmw_write_drop", 32'(obs_write), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_rmw_no_resp", 32'(obs_resp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
